// File: rtl/line_buffer_controller.sv
// rtl/line_buffer_controller.sv - line RAM sequencer and vertical column window assembler for a binary pixel stream
module line_buffer_controller #(
    parameter int ImageWidth  = 640,
    parameter int ImageHeight = 480,
    parameter int NumLines    = 2,
    localparam int AddrWidth  = $clog2(ImageWidth),
    localparam int RowWidth   = $clog2(ImageHeight)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_frame_start,
    input  logic                 i_pixel_valid,
    input  logic                 i_pixel_in,
    output logic [AddrWidth-1:0] o_ram_addr,
    output logic [NumLines-1:0]  o_ram_write_enable,
    output logic                 o_ram_data_in,
    input  logic [NumLines-1:0]  i_ram_data_out,
    output logic [NumLines:0]    o_window_out,
    output logic                 o_window_valid,
    output logic [RowWidth-1:0]  o_out_row,
    output logic [AddrWidth-1:0] o_out_col,
    output logic                 o_full_window,
    output logic                 o_frame_done,
    output logic                 o_busy
);
    localparam int SelWidth = (NumLines > 1) ? $clog2(NumLines) : 1;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t               r_state;
    logic [AddrWidth-1:0] r_col;
    logic [RowWidth-1:0]  r_row;
    logic [SelWidth-1:0]  r_sel;

    logic                 r_s1_valid;
    logic                 r_s1_pix;
    logic [AddrWidth-1:0] r_s1_col;
    logic [RowWidth-1:0]  r_s1_row;
    logic [SelWidth-1:0]  r_s1_sel;
    logic                 r_s1_last;

    logic                 r_win_valid;
    logic [NumLines:0]    r_window;
    logic [RowWidth-1:0]  r_out_row;
    logic [AddrWidth-1:0] r_out_col;
    logic                 r_full;
    logic                 r_done;

    logic                 w_accept;
    logic                 w_col_last;
    logic                 w_row_last;
    logic [AddrWidth-1:0] w_col;
    logic [RowWidth-1:0]  w_row;
    logic [SelWidth-1:0]  w_sel;
    logic [NumLines:0]    w_window;

    // A restart makes the same-cycle pixel (0,0), so counters are bypassed to zero
    assign w_accept   = i_rst_n & i_pixel_valid & ((r_state == S_RUN) | i_frame_start);
    assign w_col      = i_frame_start ? '0 : r_col;
    assign w_row      = i_frame_start ? '0 : r_row;
    assign w_sel      = i_frame_start ? '0 : r_sel;
    assign w_col_last = (w_col == AddrWidth'(ImageWidth - 1));
    assign w_row_last = (w_row == RowWidth'(ImageHeight - 1));

    assign o_ram_addr         = w_col;
    assign o_ram_write_enable = w_accept ? (NumLines'(1) << w_sel) : '0;
    assign o_ram_data_in      = r_s1_pix;

    // RAM (sel-k mod NumLines) holds the line k above; rows above the frame top are masked
    always_comb begin
        w_window    = '0;
        w_window[0] = r_s1_pix;
        for (int k = 1; k <= NumLines; k++) begin
            for (int j = 0; j < NumLines; j++) begin
                if ((int'(r_s1_row) >= k) && (j == ((int'(r_s1_sel) + NumLines - k) % NumLines))) begin
                    w_window[k] = i_ram_data_out[j];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_sel       <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_pix    <= 1'b0;
            r_s1_col    <= '0;
            r_s1_row    <= '0;
            r_s1_sel    <= '0;
            r_s1_last   <= 1'b0;
            r_win_valid <= 1'b0;
            r_window    <= '0;
            r_out_row   <= '0;
            r_out_col   <= '0;
            r_full      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (i_frame_start) begin
                r_state <= S_RUN;
                r_col   <= '0;
                r_row   <= '0;
                r_sel   <= '0;
            end
            if (w_accept) begin
                if (!w_col_last) begin
                    r_col <= w_col + AddrWidth'(1);
                end else begin
                    r_col <= '0;
                    if (w_row_last) begin
                        r_state <= S_IDLE;
                        r_row   <= '0;
                        r_sel   <= '0;
                    end else begin
                        r_row <= w_row + RowWidth'(1);
                        r_sel <= (w_sel == SelWidth'(NumLines - 1)) ? '0 : w_sel + SelWidth'(1);
                    end
                end
                r_s1_pix  <= i_pixel_in;
                r_s1_col  <= w_col;
                r_s1_row  <= w_row;
                r_s1_sel  <= w_sel;
                r_s1_last <= w_col_last & w_row_last;
            end
            r_s1_valid  <= w_accept;
            r_win_valid <= r_s1_valid;
            r_full      <= r_s1_valid & (int'(r_s1_row) >= NumLines);
            r_done      <= r_s1_valid & r_s1_last;
            if (r_s1_valid) begin
                r_window  <= w_window;
                r_out_row <= r_s1_row;
                r_out_col <= r_s1_col;
            end
        end
    end

    assign o_window_out   = r_window;
    assign o_window_valid = r_win_valid;
    assign o_out_row      = r_out_row;
    assign o_out_col      = r_out_col;
    assign o_full_window  = r_full;
    assign o_frame_done   = r_done;
    assign o_busy         = (r_state == S_RUN) | r_s1_valid | r_win_valid;

endmodule

// File: tb/tb_line_buffer_controller.sv
// tb/tb_line_buffer_controller.sv - scoreboard bench driving a 2-line and a 3-line controller in lockstep
module tb_line_buffer_controller;
    localparam int W = 5;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic fs = 1'b0;
    logic pv = 1'b0;
    logic pix = 1'b0;
    int   cyc = 0;

    logic [2:0] addr_a, addr_b, col_a, col_b;
    logic [1:0] we_a, dout_a, row_a, row_b;
    logic [2:0] we_b, dout_b, win_a;
    logic [3:0] win_b;
    logic din_a, din_b, wv_a, wv_b, full_a, full_b, fd_a, fd_b, busy_a, busy_b;

    line_buffer_controller #(.ImageWidth(W), .ImageHeight(H), .NumLines(2)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(fs), .i_pixel_valid(pv), .i_pixel_in(pix),
        .o_ram_addr(addr_a), .o_ram_write_enable(we_a), .o_ram_data_in(din_a), .i_ram_data_out(dout_a),
        .o_window_out(win_a), .o_window_valid(wv_a), .o_out_row(row_a), .o_out_col(col_a),
        .o_full_window(full_a), .o_frame_done(fd_a), .o_busy(busy_a));

    line_buffer_controller #(.ImageWidth(W), .ImageHeight(H), .NumLines(3)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(fs), .i_pixel_valid(pv), .i_pixel_in(pix),
        .o_ram_addr(addr_b), .o_ram_write_enable(we_b), .o_ram_data_in(din_b), .i_ram_data_out(dout_b),
        .o_window_out(win_b), .o_window_valid(wv_b), .o_out_row(row_b), .o_out_col(col_b),
        .o_full_window(full_b), .o_frame_done(fd_b), .o_busy(busy_b));

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line RAM models: registered address/enable, read-before-write, data written one edge later
    logic mem_a [0:1][0:7] = '{default: 1'b1};
    logic mem_b [0:2][0:7] = '{default: 1'b1};
    logic [1:0] we_a_q = '0;
    logic [2:0] we_b_q = '0;
    logic [2:0] addr_a_q = '0;
    logic [2:0] addr_b_q = '0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            dout_a[i] <= mem_a[i][addr_a];
            if (we_a_q[i]) mem_a[i][addr_a_q] <= din_a;
        end
        for (int i = 0; i < 3; i++) begin
            dout_b[i] <= mem_b[i][addr_b];
            if (we_b_q[i]) mem_b[i][addr_b_q] <= din_b;
        end
        we_a_q   <= we_a;
        we_b_q   <= we_b;
        addr_a_q <= addr_a;
        addr_b_q <= addr_b;
    end

    typedef struct {
        int         cyc;
        int         row;
        int         col;
        logic [3:0] win;
        logic       fd;
        logic       full;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int n_vec = 0;
    int n_err = 0;

    int   m_row = 0, m_col = 0, m_sel2 = 0, m_sel3 = 0, m_phase = 0;
    logic m_run = 1'b0;
    logic acc_h1 = 1'b0, acc_h2 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic pixf(input int ph, input int r, input int c);
        return ((r + c + ph) & 1) != 0;
    endfunction

    function automatic logic [3:0] winf(input int ph, input int r, input int c, input int n);
        logic [3:0] w;
        w = '0;
        for (int k = 0; k <= n; k++) if (r >= k) w[k] = pixf(ph, r - k, c);
        return w;
    endfunction

    task automatic step(input logic s_fs, input logic s_pv);
        logic acc, run_before;
        exp_t e;
        @(posedge clk);
        #1;
        run_before = m_run;
        if (s_fs) begin
            m_run = 1'b1; m_row = 0; m_col = 0; m_sel2 = 0; m_sel3 = 0;
        end
        acc = s_pv && m_run;
        fs  = s_fs;
        pv  = s_pv;
        pix = acc ? pixf(m_phase, m_row, m_col) : 1'($urandom);
        @(negedge clk);
        chk("we_a", we_a, acc ? (32'd1 << m_sel2) : 32'd0);
        chk("we_b", we_b, acc ? (32'd1 << m_sel3) : 32'd0);
        chk("busy_a", busy_a, run_before | acc_h1 | acc_h2);
        chk("busy_b", busy_b, run_before | acc_h1 | acc_h2);
        if (acc) begin
            chk("addr_a", addr_a, m_col);
            chk("addr_b", addr_b, m_col);
            e.cyc = cyc; e.row = m_row; e.col = m_col;
            e.fd  = (m_row == H - 1) && (m_col == W - 1);
            e.win = winf(m_phase, m_row, m_col, 2); e.full = (m_row >= 2);
            qa.push_back(e);
            e.win = winf(m_phase, m_row, m_col, 3); e.full = (m_row >= 3);
            qb.push_back(e);
            if (m_col == W - 1) begin
                m_col = 0;
                if (m_row == H - 1) begin
                    m_run = 1'b0; m_row = 0; m_sel2 = 0; m_sel3 = 0;
                end else begin
                    m_row++; m_sel2 = (m_sel2 + 1) % 2; m_sel3 = (m_sel3 + 1) % 3;
                end
            end else begin
                m_col++;
            end
        end
        acc_h2 = acc_h1;
        acc_h1 = acc;
    endtask

    task automatic chk_zero();
        chk("rst_addr_a", addr_a, 0);  chk("rst_addr_b", addr_b, 0);
        chk("rst_we_a", we_a, 0);      chk("rst_we_b", we_b, 0);
        chk("rst_din_a", din_a, 0);    chk("rst_din_b", din_b, 0);
        chk("rst_win_a", win_a, 0);    chk("rst_win_b", win_b, 0);
        chk("rst_wv_a", wv_a, 0);      chk("rst_wv_b", wv_b, 0);
        chk("rst_row_a", row_a, 0);    chk("rst_row_b", row_b, 0);
        chk("rst_col_a", col_a, 0);    chk("rst_col_b", col_b, 0);
        chk("rst_full_a", full_a, 0);  chk("rst_full_b", full_b, 0);
        chk("rst_fd_a", fd_a, 0);      chk("rst_fd_b", fd_b, 0);
        chk("rst_busy_a", busy_a, 0);  chk("rst_busy_b", busy_b, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_zero();
        fs = 1'b0; pv = 1'b0;
        qa.delete(); qb.delete();
        m_run = 1'b0; m_row = 0; m_col = 0; m_sel2 = 0; m_sel3 = 0;
        acc_h1 = 1'b0; acc_h2 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_frame_out();
        for (int i = 0; i < 200 && m_run; i++) step(1'b0, 1'b1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (wv_a === 1'b1) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_window", 1, 0);
            end else begin
                e = qa.pop_front();
                chk("a_latency", cyc, e.cyc + 2);
                chk("a_row", row_a, e.row);
                chk("a_col", col_a, e.col);
                chk("a_window", win_a, e.win);
                chk("a_frame_done", fd_a, e.fd);
                chk("a_full", full_a, e.full);
            end
        end else begin
            chk("a_idle_fd_full", {fd_a, full_a}, 0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (wv_b === 1'b1) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_window", 1, 0);
            end else begin
                e = qb.pop_front();
                chk("b_latency", cyc, e.cyc + 2);
                chk("b_row", row_b, e.row);
                chk("b_col", col_b, e.col);
                chk("b_window", win_b, e.win);
                chk("b_frame_done", fd_b, e.fd);
                chk("b_full", full_b, e.full);
            end
        end else begin
            chk("b_idle_fd_full", {fd_b, full_b}, 0);
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_zero();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Valid pixels without a frame start are ignored
        repeat (4) step(1'b0, 1'b1);

        // Continuous small frame, pixel = (row+col)&1
        m_phase = 0;
        step(1'b1, 1'b1);
        run_frame_out();
        repeat (4) step(1'b0, 1'b0);

        // Gapped stream: valid 1,0,0,1,0,0...
        step(1'b1, 1'b1);
        for (int i = 1; i < 300 && m_run; i++) step(1'b0, (i % 3) == 0);
        repeat (4) step(1'b0, 1'b0);

        // Restart at (2,1) with an inverted pattern; aborted frame must not flag done
        step(1'b1, 1'b1);
        for (int i = 0; i < 200 && !(m_row == 2 && m_col == 1); i++) step(1'b0, 1'b1);
        m_phase = 1;
        step(1'b1, 1'b1);
        run_frame_out();
        repeat (4) step(1'b0, 1'b0);

        // Reset mid-frame at row 3, then a fresh frame against stale RAM contents
        m_phase = 0;
        step(1'b1, 1'b1);
        for (int i = 0; i < 200 && !(m_row == 3 && m_col == 2); i++) step(1'b0, 1'b1);
        do_reset();
        repeat (3) step(1'b0, 1'b1);
        m_phase = 1;
        step(1'b1, 1'b1);
        run_frame_out();
        repeat (4) step(1'b0, 1'b0);

        chk("drain_a", qa.size(), 0);
        chk("drain_b", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/line_buffer_controller.md
# line_buffer_controller

Sequences a bank of `NumLines` single-bit, one-line-deep RAM buffers (registered address/write-enable, read-before-write, 1-cycle read latency) for a binary pixel stream. Per pixel it generates the column address, rotates the write target across lines, and assembles a vertical column window of the current pixel plus the `NumLines` pixels directly above it. It sits between the binarised pixel source and the window/feature stages.

## Interface
- `ImageWidth`, 640, pixels per line; RAM depth; `AddrWidth = $clog2(ImageWidth)`.
- `ImageHeight`, 480, lines per frame; `RowWidth = $clog2(ImageHeight)`.
- `NumLines`, 2, number of line RAMs driven (≥1).

- `Clock` in 1: single clock; all logic on rising edge.
- `nReset` in 1: asynchronous, active-low reset.
- `FrameStart` in 1: frame start pulse; the pixel presented in the same cycle is pixel (0,0).
- `PixelValid` in 1: pixel qualifier.
- `PixelIn` in 1: binary pixel.
- `RamAddr` out AddrWidth: shared address to all line RAMs.
- `RamWriteEnable` out NumLines: one-hot write request.
- `RamDataIn` out 1: write data, shared.
- `RamDataOut` in NumLines: read data from each RAM.
- `WindowOut` out NumLines+1: bit 0 is the current pixel; bit k is the pixel k lines above.
- `WindowValid` out 1: `WindowOut`, `OutRow` and `OutCol` are valid.
- `OutRow` out RowWidth, `OutCol` out AddrWidth: coordinates of bit 0 of `WindowOut`.
- `FullWindow` out 1: qualifies `WindowValid`; set when `OutRow >= NumLines`.
- `FrameDone` out 1: one-cycle pulse with the last window of the frame.
- `Busy` out 1: high in RUN or while the pipeline is non-empty.

## Operation
- States:
  - IDLE: `PixelValid` is ignored unless `FrameStart` is high.
  - RUN: counting pixels.
- Transitions:
  - IDLE→RUN on `FrameStart`.
  - RUN→IDLE on acceptance of pixel (ImageWidth-1, ImageHeight-1).
  - `FrameStart` in RUN restarts the frame: `Col`, `Row` and `WrSel` are cleared, and the same-cycle pixel becomes (0,0).
- Accept: a pixel is accepted when `PixelValid` is high in RUN, or when `FrameStart & PixelValid` are both high.
- On accept at cycle t:
  - Combinationally drive `RamAddr=Col` and `RamWriteEnable=(1<<WrSel)`.
  - Register `PixelIn` so that `RamDataIn` carries it in t+1, matching the RAM's delayed write.
- Counters:
  - `Col` increments per accepted pixel and wraps ImageWidth-1→0.
  - On the wrap, `Row` increments and `WrSel` advances mod NumLines.
  - Non-power-of-two `ImageWidth` and `NumLines` must wrap exactly.
- Window assembly:
  - RAM `WrSel` holds line Row-NumLines and RAM (WrSel-k mod NumLines) holds line Row-k. Reads return pre-write data.
  - `WrSel`, `Row`, `Col` and the pixel are pipelined alongside the RAM read. A line change therefore never mis-selects data already in flight.
  - Bit k of `WindowOut` is forced to 0 when `OutRow < k`; stale RAM contents from a previous frame or a reset never leak into the window.
- `RamWriteEnable` is 0 whenever no pixel is accepted. `RamAddr` holds `Col`.
- Reset: every output and register is 0 and the state is IDLE. RAM contents are untouched and are masked by the `OutRow < k` rule.
- Mid-operation behaviour:
  - Reset: flushes the pipeline immediately; no `WindowValid` or `FrameDone` follows.
  - `FrameStart`: windows already in flight still emit with their original coordinates; new-frame windows follow with masking restarted.

## Timing
- Latency: a pixel accepted in cycle t produces `WindowOut`/`WindowValid` registered in cycle t+2. Throughput is 1 pixel/cycle with no stalls.
- The RAM sees address and write enable at the edge ending t and data at the edge ending t+1. The read of the same address at t returns the old line.
- `FrameDone` is high in the same cycle as the window for (ImageWidth-1, ImageHeight-1).
- `Busy` falls in the cycle after the last window is output.
- `FullWindow` equals `WindowValid & (OutRow >= NumLines)`.

## Test plan
- **Reset values:** drive `nReset`=0 asynchronously mid-cycle → all outputs read 0 immediately. After release with `PixelValid`=1 and no `FrameStart`, `RamWriteEnable` stays 0 and `WindowValid` stays 0.
- **Small frame:** ImageWidth=5, ImageHeight=4, NumLines=2, pixel = (row+col)&1, continuous stream →
  - 20 windows, each 2 cycles after its accept.
  - Window (2,3) = {bit2=(0+3)&1, bit1=(1+3)&1, bit0=(2+3)&1} = 3'b101.
  - Row 0 windows have bits 2:1 = 0.
  - `FrameDone` coincides with (3,4).
- **Gapped stream:** the same frame with `PixelValid` toggling 1,0,0,1… → identical window sequence; `RamWriteEnable` is 0 on idle cycles.
- **Rotation:** NumLines=3, ImageWidth=5 → `RamWriteEnable` is 001, 010, 100, 001 on successive lines. No cross-line corruption at the column 4→0 transition.
- **Frame restart:** `FrameStart` at row 2, col 1 → in-flight windows emit with their old coordinates. The next window is (0,0) with upper bits 0. `FrameDone` is not asserted for the aborted frame.
- **Reset mid-frame:** reset at row 3, then a new frame → after reset no window output and no `FrameDone` pulse. New-frame rows below NumLines are masked even though the RAMs hold the old data.
